// File: rtl/matrix_pkg.sv
// Shared constants, types and the 8x8 glyph font for the scrolling-text pixel source.
package matrix_pkg;

  localparam int unsigned LED_PER_FRAME = 64;
  localparam int unsigned NUM_GLYPHS    = 26;
  localparam logic [4:0]  GLYPH_BLANK   = 5'd26;

  localparam logic [31:0] FG_WORD_DEFAULT = 32'hF00F0000;
  localparam logic [31:0] BG_WORD_DEFAULT = 32'hF0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Stage-1 payload: everything stage 2 needs to pick one glyph bit.
  typedef struct packed {
    logic       valid;
    logic       last;
    logic [4:0] glyph;
    logic [5:0] bit_idx;
  } stage1_t;

  // One byte per row, row 0 in the top byte, bit 7 of each byte is column 0.
  localparam logic [63:0] FONT_ROM [NUM_GLYPHS] = '{
    64'h0000780C7CCC7600, 64'h60607C666666DC00, 64'h00003C6060603C00,
    64'h06063E6666663B00, 64'h00003C667E603C00, 64'h1C30307C30303000,
    64'h00003E66663E063C, 64'h60606C7666666600, 64'h1800381818183C00,
    64'h0C001C0C0C0CCC78, 64'h6060666C786C6600, 64'h3818181818183C00,
    64'h0000ECFED6D6C600, 64'h0000DC6666666600, 64'h00003C6666663C00,
    64'h00007C66667C6060, 64'h00003E66663E0606, 64'h00006C7660606000,
    64'h00003E603C067C00, 64'h30307C3030301C00, 64'h0000666666663E00,
    64'h00006666663C1800, 64'h0000C6D6D6FE6C00, 64'h0000663C183C6600,
    64'h00006666663E067C, 64'h00007E0C18307E00
  };

endpackage

// File: rtl/matrix_pixel_source_if.sv
// LED-word stream between the pixel source and the strip serializer.
interface matrix_pixel_source_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic        pix_last;

  modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/matrix_font_rom.sv
// Combinational glyph lookup; codes above 'z' render as an empty glyph.
module matrix_font_rom
  import matrix_pkg::*;
(
  input  logic [4:0]  code,
  output logic [63:0] glyph_c
);

  always_comb begin
    glyph_c = '0;
    if (code < GLYPH_BLANK) glyph_c = FONT_ROM[code];
  end

endmodule

// File: rtl/matrix_pixel_source.sv
// Renders a scrolling text window onto the 8x8 serpentine strip, one LED word per pixel.
module matrix_pixel_source
  import matrix_pkg::*;
#(
  parameter int unsigned NUM_CHARS       = 4,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter logic [31:0] FG_WORD         = FG_WORD_DEFAULT,
  parameter logic [31:0] BG_WORD         = BG_WORD_DEFAULT,
  localparam int unsigned ADDR_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
  localparam int unsigned COL_W  = $clog2(NUM_CHARS * 8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  msg_we,
  input  logic [ADDR_W-1:0]     msg_addr,
  input  logic [4:0]            msg_char,
  matrix_pixel_source_if.master pix,
  output logic [COL_W-1:0]      scroll_col
);

  localparam int unsigned NUM_COLS = NUM_CHARS * 8;
  localparam int unsigned FRAME_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [5:0]  LAST_IDX = 6'(LED_PER_FRAME - 1);

  state_t               state_q, state_d;
  logic [5:0]           k_q, k_d;
  logic [4:0]           msg_q    [NUM_CHARS];
  logic [4:0]           msg_wt   [NUM_CHARS];
  logic [4:0]           shadow_q [NUM_CHARS];
  logic [4:0]           shadow_d [NUM_CHARS];
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [COL_W-1:0]     scroll_q, scroll_d;
  stage1_t              s1_q, s1_d;
  logic                 valid_q, last_q;
  logic [31:0]          data_q;

  logic                 advance_c, frame_end_c, start_c, issue_c, lit_c;
  logic [5:0]           issue_k_c;
  logic [2:0]           row_c, col_c;
  logic [COL_W:0]       vsum_c;
  logic [COL_W-1:0]     vcol_c;
  logic [ADDR_W-1:0]    char_c;
  logic [63:0]          glyph_bits_c;

  assign advance_c   = !valid_q || pix.pix_ready;
  assign frame_end_c = valid_q && pix.pix_ready && last_q;

  // Frame sequencer: issues k=0..63 into stage 1, then waits for the last transfer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    start_c = 1'b0;
    issue_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          start_c = 1'b1;
          issue_c = 1'b1;
          k_d     = 6'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (advance_c) begin
          issue_c = 1'b1;
          k_d     = k_q + 6'd1;
          if (k_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (frame_end_c) begin
          if (enable) begin
            start_c = 1'b1;
            issue_c = 1'b1;
            k_d     = 6'd1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Write-through so a write coinciding with frame start lands in that frame's shadow.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      msg_wt[i] = msg_q[i];
      if (msg_we && (32'(msg_addr) == i)) msg_wt[i] = msg_char;
      shadow_d[i] = start_c ? msg_wt[i] : shadow_q[i];
    end
  end

  always_comb begin
    frame_d  = frame_q;
    scroll_d = scroll_q;
    if (frame_end_c) begin
      if (32'(frame_q) == FRAMES_PER_STEP - 1) begin
        frame_d  = '0;
        scroll_d = (32'(scroll_q) == NUM_COLS - 1) ? '0 : scroll_q + COL_W'(1);
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  // Stage 1 uses next-state scroll/shadow so a back-to-back frame sees its own values.
  always_comb begin
    issue_k_c = start_c ? 6'd0 : k_q;
    row_c     = issue_k_c[5:3];
    col_c     = row_c[0] ? issue_k_c[2:0] : 3'd7 - issue_k_c[2:0];
    vsum_c    = {1'b0, scroll_d} + (COL_W + 1)'(col_c);
    if (32'(vsum_c) >= NUM_COLS) vsum_c = vsum_c - (COL_W + 1)'(NUM_COLS);
    vcol_c    = vsum_c[COL_W-1:0];
    char_c    = ADDR_W'(vcol_c >> 3);
    s1_d.valid   = issue_c;
    s1_d.last    = (issue_k_c == LAST_IDX);
    s1_d.glyph   = shadow_d[char_c];
    s1_d.bit_idx = {row_c, vcol_c[2:0]};
  end

  matrix_font_rom u_font_rom (
    .code    (s1_q.glyph),
    .glyph_c (glyph_bits_c)
  );

  assign lit_c = (s1_q.glyph < GLYPH_BLANK) && glyph_bits_c[6'd63 - s1_q.bit_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q  <= '0;
      scroll_q <= '0;
      s1_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= BG_WORD;
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
        msg_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      frame_q  <= frame_d;
      scroll_q <= scroll_d;
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
        msg_q[i]    <= msg_wt[i];
        shadow_q[i] <= shadow_d[i];
      end
      if (advance_c) begin
        s1_q    <= s1_d;
        valid_q <= s1_q.valid;
        last_q  <= s1_q.valid && s1_q.last;
        if (s1_q.valid) data_q <= lit_c ? FG_WORD : BG_WORD;
      end
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.pix_data  = data_q;
  assign pix.pix_last  = last_q;
  assign scroll_col    = scroll_q;

endmodule

// File: tb/tb_matrix_pixel_source.sv
// Directed bench for matrix_pixel_source: default 4-char instance plus a 2-char, 1-frame-per-step instance.
`timescale 1ns/1ps
module tb_matrix_pixel_source;

  localparam logic [31:0] FG = 32'hF00F0000;
  localparam logic [31:0] BG = 32'hF0000000;
  localparam logic [63:0] LAST_ONLY_63 = 64'h8000_0000_0000_0000;
  localparam int ACT_NONE  = 0;
  localparam int ACT_WRITE = 1;
  localparam int ACT_ENOFF = 2;
  localparam int ACT_RESET = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, enable_a, msg_we_a, rdy_a;
  logic [1:0] msg_addr_a;
  logic [4:0] msg_char_a;
  logic [4:0] scroll_a;
  logic       reset_b, enable_b, msg_we_b, rdy_b;
  logic [0:0] msg_addr_b;
  logic [4:0] msg_char_b;
  logic [3:0] scroll_b;

  matrix_pixel_source_if ifa ();
  matrix_pixel_source_if ifb ();
  assign ifa.pix_ready = rdy_a;
  assign ifb.pix_ready = rdy_b;

  matrix_pixel_source #(.NUM_CHARS(4), .FRAMES_PER_STEP(8)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .msg_we(msg_we_a),
    .msg_addr(msg_addr_a), .msg_char(msg_char_a), .pix(ifa), .scroll_col(scroll_a));

  matrix_pixel_source #(.NUM_CHARS(2), .FRAMES_PER_STEP(1)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .msg_we(msg_we_b),
    .msg_addr(msg_addr_b), .msg_char(msg_char_b), .pix(ifb), .scroll_col(scroll_b));

  logic        sel_b;
  logic        cur_valid, cur_ready, cur_last;
  logic [31:0] cur_data;
  assign cur_valid = sel_b ? ifb.pix_valid : ifa.pix_valid;
  assign cur_ready = sel_b ? rdy_b : rdy_a;
  assign cur_last  = sel_b ? ifb.pix_last : ifa.pix_last;
  assign cur_data  = sel_b ? ifb.pix_data : ifa.pix_data;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cap_n, cap_first;
  logic [31:0] cap_data [64];
  logic [63:0] cap_last;

  function automatic int fg_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (cap_data[i] === FG) c++;
    return c;
  endfunction

  // Collects one frame from the selected instance, optionally acting on dut_a at word act_n.
  task automatic capture(input int act_n, input int act);
    int cyc = 0;
    cap_n = 0; cap_first = -1; cap_last = '0;
    while (cap_n < 64 && cyc < 300) begin
      @(negedge clk); cyc++;
      msg_we_a = 1'b0;
      if (cur_valid && cap_n == act_n) begin
        if (act == ACT_WRITE) begin msg_we_a = 1'b1; msg_addr_a = 2'd0; msg_char_a = 5'd26; end
        else if (act == ACT_ENOFF) enable_a = 1'b0;
        else if (act == ACT_RESET) begin reset_a = 1'b1; return; end
      end
      if (cur_valid && cur_ready) begin
        if (cap_first < 0) cap_first = cyc;
        cap_data[cap_n] = cur_data; cap_last[cap_n] = cur_last; cap_n++;
      end
    end
  endtask

  task automatic test_reset();
    sel_b = 1'b0;
    reset_a = 1'b1; enable_a = 1'b0; msg_we_a = 1'b0; msg_addr_a = '0; msg_char_a = '0; rdy_a = 1'b1;
    reset_b = 1'b1; enable_b = 1'b0; msg_we_b = 1'b0; msg_addr_b = '0; msg_char_b = '0; rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (ifa.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", ifa.pix_valid); end
    tests_run++; if (ifa.pix_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %b expected 0", ifa.pix_last); end
    tests_run++; if (ifa.pix_data !== BG) begin tests_failed++; $display("FAIL reset_data: got %h expected %h", ifa.pix_data, BG); end
    tests_run++; if (scroll_a !== 5'd0) begin tests_failed++; $display("FAIL reset_scroll: got %0d expected 0", scroll_a); end
  endtask

  task automatic test_first_frame();
    int ks[9] = '{16, 19, 20, 22, 23, 28, 29, 44, 52};
    logic [31:0] ex[9] = '{BG, FG, FG, FG, BG, FG, FG, FG, FG};
    int bad = 0;
    reset_a = 1'b0; enable_a = 1'b1;
    @(negedge clk);
    tests_run++; if (ifa.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early_valid: got %b expected 0", ifa.pix_valid); end
    capture(-1, ACT_NONE);
    tests_run++; if (cap_n !== 64) begin tests_failed++; $display("FAIL first_count: got %0d expected 64", cap_n); end
    tests_run++; if (cap_first !== 1) begin tests_failed++; $display("FAIL first_latency: got %0d expected 1", cap_first); end
    tests_run++; if (cap_last !== LAST_ONLY_63) begin tests_failed++; $display("FAIL first_last: got %h expected %h", cap_last, LAST_ONLY_63); end
    for (int i = 0; i < 16; i++) if (cap_data[i] !== BG) bad++;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL first_rows01_bg: got %0d non-BG expected 0", bad); end
    for (int i = 0; i < 9; i++) begin
      tests_run++; if (cap_data[ks[i]] !== ex[i]) begin tests_failed++; $display("FAIL first_k%0d: got %h expected %h", ks[i], cap_data[ks[i]], ex[i]); end
    end
    tests_run++; if (fg_count(64) !== 20) begin tests_failed++; $display("FAIL first_fg_count: got %0d expected 20", fg_count(64)); end
    tests_run++; if (scroll_a !== 5'd0) begin tests_failed++; $display("FAIL first_scroll: got %0d expected 0", scroll_a); end
  endtask

  task automatic test_stall();
    int n = 0, cyc = 0, unstable = 0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    bit stalled = 1'b0;
    sel_b = 1'b0; cap_last = '0;
    while (n < 64 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (ifa.pix_valid && n == 10 && !stalled) begin
        held_d = ifa.pix_data; held_l = ifa.pix_last; rdy_a = 1'b0; stalled = 1'b1;
        repeat (5) begin
          @(negedge clk); cyc++;
          if (ifa.pix_valid !== 1'b1 || ifa.pix_data !== held_d || ifa.pix_last !== held_l) unstable++;
        end
        rdy_a = 1'b1;
      end
      if (ifa.pix_valid && rdy_a) begin cap_data[n] = ifa.pix_data; cap_last[n] = ifa.pix_last; n++; end
    end
    tests_run++; if (n !== 64) begin tests_failed++; $display("FAIL stall_count: got %0d expected 64", n); end
    tests_run++; if (unstable !== 0) begin tests_failed++; $display("FAIL stall_stable: got %0d changed cycles expected 0", unstable); end
    tests_run++; if (held_l !== 1'b0) begin tests_failed++; $display("FAIL stall_held_last: got %b expected 0", held_l); end
    tests_run++; if (cap_data[10] !== BG) begin tests_failed++; $display("FAIL stall_k10: got %h expected %h", cap_data[10], BG); end
    tests_run++; if (cap_data[19] !== FG) begin tests_failed++; $display("FAIL stall_k19: got %h expected %h", cap_data[19], FG); end
    tests_run++; if (cap_last !== LAST_ONLY_63) begin tests_failed++; $display("FAIL stall_last: got %h expected %h", cap_last, LAST_ONLY_63); end
    tests_run++; if (fg_count(64) !== 20) begin tests_failed++; $display("FAIL stall_fg_count: got %0d expected 20", fg_count(64)); end
  endtask

  task automatic test_msg_write();
    sel_b = 1'b0;
    capture(30, ACT_WRITE);
    tests_run++; if (cap_n !== 64) begin tests_failed++; $display("FAIL write_inflight_count: got %0d expected 64", cap_n); end
    tests_run++; if (cap_data[44] !== FG) begin tests_failed++; $display("FAIL write_inflight_k44: got %h expected %h", cap_data[44], FG); end
    tests_run++; if (fg_count(64) !== 20) begin tests_failed++; $display("FAIL write_inflight_fg: got %0d expected 20", fg_count(64)); end
    capture(-1, ACT_NONE);
    tests_run++; if (fg_count(64) !== 0) begin tests_failed++; $display("FAIL write_blank_fg: got %0d expected 0", fg_count(64)); end
    // Write lands in the same cycle as the next frame start.
    msg_we_a = 1'b1; msg_addr_a = 2'd0; msg_char_a = 5'd0;
    capture(-1, ACT_NONE);
    tests_run++; if (fg_count(64) !== 20) begin tests_failed++; $display("FAIL write_through_fg: got %0d expected 20", fg_count(64)); end
    capture(-1, ACT_NONE);
    capture(-1, ACT_NONE);
    tests_run++; if (scroll_a !== 5'd0) begin tests_failed++; $display("FAIL scroll_hold_f7: got %0d expected 0", scroll_a); end
    capture(-1, ACT_NONE);
    @(negedge clk);
    tests_run++; if (scroll_a !== 5'd1) begin tests_failed++; $display("FAIL scroll_step_f8: got %0d expected 1", scroll_a); end
  endtask

  task automatic test_reset_mid();
    sel_b = 1'b0;
    capture(40, ACT_RESET);
    tests_run++; if (cap_n !== 40) begin tests_failed++; $display("FAIL rmid_count: got %0d expected 40", cap_n); end
    tests_run++; if (cap_data[23] !== FG) begin tests_failed++; $display("FAIL rmid_scroll1_k23: got %h expected %h", cap_data[23], FG); end
    tests_run++; if (cap_data[19] !== BG) begin tests_failed++; $display("FAIL rmid_scroll1_k19: got %h expected %h", cap_data[19], BG); end
    @(negedge clk);
    tests_run++; if (ifa.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b expected 0", ifa.pix_valid); end
    tests_run++; if (scroll_a !== 5'd0) begin tests_failed++; $display("FAIL rmid_scroll: got %0d expected 0", scroll_a); end
    reset_a = 1'b0;
    @(negedge clk);
    capture(-1, ACT_NONE);
    tests_run++; if (cap_first !== 1) begin tests_failed++; $display("FAIL rmid_restart_latency: got %0d expected 1", cap_first); end
    tests_run++; if (cap_last !== LAST_ONLY_63) begin tests_failed++; $display("FAIL rmid_restart_last: got %h expected %h", cap_last, LAST_ONLY_63); end
    tests_run++; if (cap_data[19] !== FG) begin tests_failed++; $display("FAIL rmid_restart_k19: got %h expected %h", cap_data[19], FG); end
    tests_run++; if (fg_count(64) !== 20) begin tests_failed++; $display("FAIL rmid_restart_fg: got %0d expected 20", fg_count(64)); end
  endtask

  task automatic test_enable_off();
    int vcount = 0;
    sel_b = 1'b0;
    capture(20, ACT_ENOFF);
    tests_run++; if (cap_n !== 64) begin tests_failed++; $display("FAIL enoff_count: got %0d expected 64", cap_n); end
    tests_run++; if (cap_last !== LAST_ONLY_63) begin tests_failed++; $display("FAIL enoff_last: got %h expected %h", cap_last, LAST_ONLY_63); end
    repeat (10) begin @(negedge clk); if (ifa.pix_valid !== 1'b0) vcount++; end
    tests_run++; if (vcount !== 0) begin tests_failed++; $display("FAIL enoff_idle_valid: got %0d valid cycles expected 0", vcount); end
    enable_a = 1'b1;
    @(negedge clk);
    tests_run++; if (ifa.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL enon_early_valid: got %b expected 0", ifa.pix_valid); end
    @(negedge clk);
    tests_run++; if (ifa.pix_valid !== 1'b1) begin tests_failed++; $display("FAIL enon_valid: got %b expected 1", ifa.pix_valid); end
    tests_run++; if (ifa.pix_data !== BG) begin tests_failed++; $display("FAIL enon_k0: got %h expected %h", ifa.pix_data, BG); end
    enable_a = 1'b0;
  endtask

  task automatic test_scroll_wrap();
    sel_b = 1'b1;
    reset_b = 1'b0; enable_b = 1'b0; msg_we_b = 1'b1; msg_addr_b = 1'b1; msg_char_b = 5'd26;
    @(negedge clk);
    msg_we_b = 1'b0;
    tests_run++; if (ifb.pix_valid !== 1'b0) begin tests_failed++; $display("FAIL b_idle_valid: got %b expected 0", ifb.pix_valid); end
    enable_b = 1'b1;
    capture(-1, ACT_NONE);
    tests_run++; if (fg_count(64) !== 20) begin tests_failed++; $display("FAIL b_f1_fg: got %0d expected 20", fg_count(64)); end
    capture(-1, ACT_NONE);
    tests_run++; if (scroll_b !== 4'd1) begin tests_failed++; $display("FAIL b_f2_scroll: got %0d expected 1", scroll_b); end
    tests_run++; if (cap_data[23] !== FG) begin tests_failed++; $display("FAIL b_f2_k23: got %h expected %h", cap_data[23], FG); end
    tests_run++; if (cap_data[19] !== BG) begin tests_failed++; $display("FAIL b_f2_k19: got %h expected %h", cap_data[19], BG); end
    tests_run++; if (cap_data[20] !== FG) begin tests_failed++; $display("FAIL b_f2_k20: got %h expected %h", cap_data[20], FG); end
    for (int f = 3; f <= 16; f++) begin
      capture(-1, ACT_NONE);
      if (f == 9) begin
        tests_run++; if (fg_count(64) !== 0) begin tests_failed++; $display("FAIL b_f9_blank_fg: got %0d expected 0", fg_count(64)); end
      end
    end
    tests_run++; if (scroll_b !== 4'd15) begin tests_failed++; $display("FAIL b_f16_scroll: got %0d expected 15", scroll_b); end
    @(negedge clk);
    tests_run++; if (scroll_b !== 4'd0) begin tests_failed++; $display("FAIL b_wrap_scroll: got %0d expected 0", scroll_b); end
    enable_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stall();
    test_msg_write();
    test_reset_mid();
    test_enable_off();
    test_scroll_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
